track_section_arbiter: RTL and testbench

Arbiter for the shared switch/crossing section of the layout, used by two trains (A, B). It grants the section to one train at a time. Before granting, it drives the requester's switch route and waits a fixed settle time. It holds the grant until that train's exit sensor fires, then releases the section and rotates priority. It sits between the per-train sequencers, which raise requests, and the switch/track-power drivers.

---
 rtl/track_section_arbiter_pkg.sv | 38 +++
 rtl/track_section_arbiter_if.sv | 32 +++
 rtl/track_section_arbiter_cycle_timer.sv | 38 +++
 rtl/track_section_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_track_section_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/track_section_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// track_pkg: shared types and constants for the track section arbiter.
//   state_e    : arbiter states IDLE, SET_SW, GRANT, RELEASE, FAULT
//   owner_e    : section owner encoding, OWN_A = 0, OWN_B = 1
//   ROUTE_W    : width of a switch pattern {sw1,sw2,sw3}
//   SW_RESET_DEFAULT : switch pattern driven out of reset
//   other_owner(): the train that is not the given owner
// ---------------------------------------------------------------------------
package track_pkg;

    localparam int ROUTE_W = 3;

    localparam logic [ROUTE_W-1:0] SW_RESET_DEFAULT = 3'b110;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_SW  = 3'd1,
        GRANT   = 3'd2,
        RELEASE = 3'd3,
        FAULT   = 3'd4
    } state_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        owner_e r;
        if (o == OWN_A) begin
            r = OWN_B;
        end else begin
            r = OWN_A;
        end
        return r;
    endfunction

endpackage

// File: rtl/track_section_arbiter_if.sv
// ---------------------------------------------------------------------------
// track_section_arbiter_if: request / route / exit signals from the two train
// sequencers and the switch / track-power drive back to the layout.
//   master : sequencer side (drives req/route/exit, observes drive outputs)
//   slave  : arbiter side   (observes req/route/exit, drives sw/grant/busy/fault)
// ---------------------------------------------------------------------------
interface track_section_arbiter_if;
    import track_pkg::*;

    logic               req_a;
    logic               req_b;
    logic [ROUTE_W-1:0] route_a;
    logic [ROUTE_W-1:0] route_b;
    logic               exit_a;
    logic               exit_b;
    logic [ROUTE_W-1:0] sw;
    logic               grant_a;
    logic               grant_b;
    logic               busy;
    logic               fault;

    modport master (
        output req_a, req_b, route_a, route_b, exit_a, exit_b,
        input  sw, grant_a, grant_b, busy, fault
    );

    modport slave (
        input  req_a, req_b, route_a, route_b, exit_a, exit_b,
        output sw, grant_a, grant_b, busy, fault
    );

endinterface

// File: rtl/track_section_arbiter_cycle_timer.sv
// ---------------------------------------------------------------------------
// cycle_timer: clearable saturating up-counter with a terminal-count compare.
// Shared by the switch-settle phase and the grant watchdog.
//   clk, reset  : clock, synchronous active-high reset (count -> 0)
//   clear       : synchronous restart at 0 (wins over enable)
//   enable      : count up by one, sticking at all-ones
//   terminal    : value compared against the current count
//   at_terminal : current count equals terminal
// ---------------------------------------------------------------------------
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] terminal,
    output logic         at_terminal
);

    logic [W-1:0] count_r;

    // Counter register: restart on clear, otherwise count up and saturate.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (enable && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign at_terminal = (count_r == terminal);

endmodule

// File: rtl/track_section_arbiter.sv
// ---------------------------------------------------------------------------
// track_section_arbiter: grants the shared switch/crossing section to train A
// or train B. A winning request first drives its switch route and waits
// SETTLE_CYCLES, then the grant (track power) is held until the owner's exit
// sensor rises; the section is then released and priority passes to the
// other train.
//
// Ports
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : track_section_arbiter_if.slave
//           req_a/req_b, route_a/route_b, exit_a/exit_b in;
//           sw, grant_a/grant_b, busy, fault out (all registered)
//
// Build option
//   WATCHDOG_EN : when defined, a grant held for TIMEOUT_CYCLES moves to a
//                 sticky FAULT state (grants off, fault high) left only by
//                 reset. Undefined: no FAULT state, fault tied low.
// ---------------------------------------------------------------------------
module track_section_arbiter
    import track_pkg::*;
#(
    parameter int unsigned        SETTLE_CYCLES  = 50000,
    parameter int unsigned        TIMEOUT_CYCLES = 20000000,
    parameter logic [ROUTE_W-1:0] SW_RESET       = SW_RESET_DEFAULT
) (
    input logic                   clk,
    input logic                   reset,
    track_section_arbiter_if.slave bus
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ?
                                      SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int          CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);
`ifdef WATCHDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    state_e             state_r;
    state_e             state_s;
    owner_e             owner_r;
    owner_e             owner_s;
    owner_e             prio_r;
    owner_e             prio_s;
    logic [ROUTE_W-1:0] sw_r;
    logic [ROUTE_W-1:0] sw_s;
    logic               exit_a_prev_r;
    logic               exit_b_prev_r;
    logic               grant_a_r;
    logic               grant_b_r;
    logic               busy_r;
    logic               fault_r;

    logic               owner_req_s;
    logic               owner_rise_s;
    logic               tmr_clear_s;
    logic               tmr_enable_s;
    logic               tmr_at_tc_s;
    logic [CNT_W-1:0]   tmr_terminal_s;

    // Terminal-count select: the settle length everywhere except GRANT.
    always_comb begin
`ifdef WATCHDOG_EN
        if (state_r == GRANT) begin
            tmr_terminal_s = TIMEOUT_TC;
        end else begin
            tmr_terminal_s = SETTLE_TC;
        end
`else
        tmr_terminal_s = SETTLE_TC;
`endif
    end

    cycle_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .clear       (tmr_clear_s),
        .enable      (tmr_enable_s),
        .terminal    (tmr_terminal_s),
        .at_terminal (tmr_at_tc_s)
    );

    // Owner's request level and exit rising edge, selected by current owner.
    always_comb begin
        if (owner_r == OWN_A) begin
            owner_req_s  = bus.req_a;
            owner_rise_s = bus.exit_a & ~exit_a_prev_r;
        end else begin
            owner_req_s  = bus.req_b;
            owner_rise_s = bus.exit_b & ~exit_b_prev_r;
        end
    end

    // Next-state, owner, route latch, priority and timer control.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        sw_s         = sw_r;
        prio_s       = prio_r;
        tmr_clear_s  = 1'b0;
        tmr_enable_s = 1'b0;
        case (state_r)
            IDLE: begin
                // A wins if alone or if it holds priority in a tie.
                if (bus.req_a && (!bus.req_b || (prio_r == OWN_A))) begin
                    owner_s     = OWN_A;
                    sw_s        = bus.route_a;
                    tmr_clear_s = 1'b1;
                    state_s     = SET_SW;
                end else if (bus.req_b) begin
                    owner_s     = OWN_B;
                    sw_s        = bus.route_b;
                    tmr_clear_s = 1'b1;
                    state_s     = SET_SW;
                end else begin
                    state_s     = IDLE;
                end
            end
            SET_SW: begin
                tmr_enable_s = 1'b1;
                // A request withdrawn before the grant abandons the win;
                // the latched route stays on the switches.
                if (!owner_req_s) begin
                    state_s = IDLE;
                end else if (tmr_at_tc_s) begin
                    state_s = GRANT;
`ifdef WATCHDOG_EN
                    tmr_clear_s = 1'b1;
`endif
                end else begin
                    state_s = SET_SW;
                end
            end
            GRANT: begin
                // Owner's req is ignored here: the train is in the section.
                if (owner_rise_s) begin
                    state_s = RELEASE;
                end else begin
`ifdef WATCHDOG_EN
                    tmr_enable_s = 1'b1;
                    if (tmr_at_tc_s) begin
                        state_s = FAULT;
                    end else begin
                        state_s = GRANT;
                    end
`else
                    state_s = GRANT;
`endif
                end
            end
            RELEASE: begin
                prio_s  = other_owner(owner_r);
                state_s = IDLE;
            end
`ifdef WATCHDOG_EN
            FAULT: begin
                state_s = FAULT;
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, owner, route, priority and exit-history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            owner_r       <= OWN_A;
            prio_r        <= OWN_A;
            sw_r          <= SW_RESET;
            exit_a_prev_r <= 1'b0;
            exit_b_prev_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            owner_r       <= owner_s;
            prio_r        <= prio_s;
            sw_r          <= sw_s;
            exit_a_prev_r <= bus.exit_a;
            exit_b_prev_r <= bus.exit_b;
        end
    end

    // Output registers decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_a_r <= 1'b0;
            grant_b_r <= 1'b0;
            busy_r    <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            grant_a_r <= (state_s == GRANT) && (owner_s == OWN_A);
            grant_b_r <= (state_s == GRANT) && (owner_s == OWN_B);
            busy_r    <= (state_s != IDLE);
`ifdef WATCHDOG_EN
            fault_r   <= (state_s == FAULT);
`else
            fault_r   <= 1'b0;
`endif
        end
    end

    assign bus.sw      = sw_r;
    assign bus.grant_a = grant_a_r;
    assign bus.grant_b = grant_b_r;
    assign bus.busy    = busy_r;
    assign bus.fault   = fault_r;

endmodule

// File: tb/tb_track_section_arbiter.sv
// Self-checking bench for track_section_arbiter (SETTLE_CYCLES=4,
// TIMEOUT_CYCLES=20). Directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_track_section_arbiter;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 20;
`ifdef WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    track_section_arbiter_if bus ();

    track_section_arbiter #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SW_RESET       (3'b110)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // drive values applied by step()
    bit       d_ra, d_rb, d_ea, d_eb, d_rst;
    bit [2:0] d_rta, d_rtb;

    // behavioural model: who holds or is claiming the section and how far along
    int       m_owner;        // -1 free, 0 train A, 1 train B
    int       m_settle_left;  // cycles of switch settling still to go
    int       m_age;          // cycles the grant has been held
    bit       m_granted, m_releasing, m_faulted, m_prio_b;
    bit       m_prev_a, m_prev_b;
    bit [2:0] m_sw;

    int vectors = 0;
    int miscompares = 0;
    int checks = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at vector %0d: got %0h expected %0h", name, vectors, act, exp);
        end
    endtask

    task automatic model_step();
        bit rise_a, rise_b, own_req, own_rise;
        if (d_rst) begin
            m_owner = -1; m_settle_left = 0; m_age = 0;
            m_granted = 0; m_releasing = 0; m_faulted = 0; m_prio_b = 0;
            m_prev_a = 0; m_prev_b = 0; m_sw = 3'b110;
        end else begin
            rise_a = d_ea && !m_prev_a;
            rise_b = d_eb && !m_prev_b;
            m_prev_a = d_ea;
            m_prev_b = d_eb;
            own_req  = (m_owner == 0) ? d_ra : d_rb;
            own_rise = (m_owner == 0) ? rise_a : rise_b;
            if (m_faulted) begin
                m_faulted = 1;
            end else if (m_releasing) begin
                m_prio_b = (m_owner == 0);
                m_owner = -1;
                m_releasing = 0;
            end else if (m_granted) begin
                if (own_rise) begin
                    m_granted = 0;
                    m_releasing = 1;
                end else if (WD) begin
                    m_age++;
                    if (m_age >= TIMEOUT) begin
                        m_granted = 0;
                        m_faulted = 1;
                    end
                end
            end else if (m_owner >= 0) begin
                if (!own_req) begin
                    m_owner = -1;
                end else begin
                    m_settle_left--;
                    if (m_settle_left == 0) begin
                        m_granted = 1;
                        m_age = 0;
                    end
                end
            end else begin
                if (d_ra && (!d_rb || !m_prio_b)) begin
                    m_owner = 0; m_sw = d_rta; m_settle_left = SETTLE;
                end else if (d_rb) begin
                    m_owner = 1; m_sw = d_rtb; m_settle_left = SETTLE;
                end
            end
        end
    endtask

    // apply drive values for one clock, advance the model, compare everything
    task automatic step();
        reset       = d_rst;
        bus.req_a   = d_ra;
        bus.req_b   = d_rb;
        bus.route_a = d_rta;
        bus.route_b = d_rtb;
        bus.exit_a  = d_ea;
        bus.exit_b  = d_eb;
        @(posedge clk);
        #1;
        model_step();
        vectors++;
        check("sw",      {5'd0, bus.sw},      {5'd0, m_sw});
        check("grant_a", {7'd0, bus.grant_a}, {7'd0, (m_granted && m_owner == 0)});
        check("grant_b", {7'd0, bus.grant_b}, {7'd0, (m_granted && m_owner == 1)});
        check("busy",    {7'd0, bus.busy},    {7'd0, (m_owner >= 0 || m_faulted)});
        check("fault",   {7'd0, bus.fault},   {7'd0, m_faulted});
        check("excl",    {7'd0, bus.grant_a & bus.grant_b}, 8'd0);
    endtask

    task automatic idle_inputs();
        d_ra = 0; d_rb = 0; d_ea = 0; d_eb = 0; d_rst = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        d_rst = 1;
        step();
        d_rst = 0;
    endtask

    initial begin
        idle_inputs();
        d_rta = 3'b000; d_rtb = 3'b000;

        // reset, then idle for 10 cycles
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            check("lit_idle_sw",   {5'd0, bus.sw}, 8'h06);
            check("lit_idle_busy", {7'd0, bus.busy}, 8'd0);
            check("lit_idle_gnt",  {6'd0, bus.grant_a, bus.grant_b}, 8'd0);
        end

        // single A request: route on the next edge, grant SETTLE edges later
        d_ra = 1; d_rta = 3'b001;
        step();
        check("lit_a_sw", {5'd0, bus.sw}, 8'h01);
        check("lit_a_busy", {7'd0, bus.busy}, 8'd1);
        for (int i = 0; i < SETTLE - 1; i++) begin
            step();
            check("lit_a_settle", {7'd0, bus.grant_a}, 8'd0);
        end
        step();
        check("lit_a_grant", {7'd0, bus.grant_a}, 8'd1);
        for (int i = 0; i < 4; i++) step();
        d_ea = 1;
        step();
        check("lit_a_release_gnt", {7'd0, bus.grant_a}, 8'd0);
        check("lit_a_release_busy", {7'd0, bus.busy}, 8'd1);
        d_ea = 0; d_ra = 0;
        step();
        check("lit_a_idle_busy", {7'd0, bus.busy}, 8'd0);
        check("lit_a_idle_sw", {5'd0, bus.sw}, 8'h01);

        // tie after reset: A first, then B from IDLE after A leaves
        do_reset();
        d_ra = 1; d_rb = 1; d_rta = 3'b010; d_rtb = 3'b101;
        step();
        check("lit_tie_sw_a", {5'd0, bus.sw}, 8'h02);
        for (int i = 0; i < SETTLE; i++) step();
        check("lit_tie_grant_a", {6'd0, bus.grant_a, bus.grant_b}, 8'h02);
        d_ea = 1;
        step();
        check("lit_tie_rel", {6'd0, bus.grant_a, bus.grant_b}, 8'h00);
        d_ea = 0; d_ra = 0;
        step();
        check("lit_tie_idle", {7'd0, bus.busy}, 8'd0);
        step();
        check("lit_tie_sw_b", {5'd0, bus.sw}, 8'h05);
        for (int i = 0; i < SETTLE - 1; i++) step();
        check("lit_tie_b_wait", {7'd0, bus.grant_b}, 8'd0);
        step();
        check("lit_tie_grant_b", {6'd0, bus.grant_a, bus.grant_b}, 8'h01);
        d_eb = 1; step(); d_eb = 0; d_rb = 0; step();

        // B withdraws during settling: no grant, priority stays with A
        do_reset();
        d_rb = 1; d_rtb = 3'b100;
        step(); step(); step();
        d_rb = 0;
        step();
        check("lit_abort_busy", {7'd0, bus.busy}, 8'd0);
        check("lit_abort_sw", {5'd0, bus.sw}, 8'h04);
        d_ra = 1; d_rb = 1; d_rta = 3'b001; d_rtb = 3'b111;
        step();
        check("lit_abort_prio", {5'd0, bus.sw}, 8'h01);

        // foreign exit and own req drop are ignored while granted
        do_reset();
        d_ra = 1; d_rta = 3'b111;
        for (int i = 0; i <= SETTLE; i++) step();
        check("lit_hold_grant", {7'd0, bus.grant_a}, 8'd1);
        d_eb = 1; d_ra = 0;
        step();
        check("lit_hold_ignore1", {7'd0, bus.grant_a}, 8'd1);
        d_eb = 0;
        step();
        check("lit_hold_ignore2", {7'd0, bus.grant_a}, 8'd1);
        d_ea = 1;
        step();
        check("lit_hold_exit", {7'd0, bus.grant_a}, 8'd0);
        d_ea = 0;
        step();

        if (WD) begin
            // grant held with no exit: fault after TIMEOUT edges in GRANT
            do_reset();
            d_ra = 1; d_rta = 3'b011;
            for (int i = 0; i <= SETTLE; i++) step();
            for (int i = 0; i < TIMEOUT - 1; i++) step();
            check("lit_wd_before", {6'd0, bus.grant_a, bus.fault}, 8'h02);
            step();
            check("lit_wd_fault", {6'd0, bus.grant_a, bus.fault}, 8'h01);
            d_ra = 0; d_rb = 1;
            for (int i = 0; i < 5; i++) step();
            check("lit_wd_sticky", {6'd0, bus.fault, bus.busy}, 8'h03);
            do_reset();
            check("lit_wd_clear", {7'd0, bus.fault}, 8'd0);
        end

        // randomized traffic checked every cycle against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7, 0) == 0) d_ra = ~d_ra;
            if ($urandom_range(7, 0) == 0) d_rb = ~d_rb;
            d_rta = 3'($urandom_range(7, 0));
            d_rtb = 3'($urandom_range(7, 0));
            d_ea  = ($urandom_range(5, 0) == 0);
            d_eb  = ($urandom_range(5, 0) == 0);
            d_rst = ($urandom_range(299, 0) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
